// File: rtl/mm_operand_sequencer.sv
// Operand sequencer for the 3x3 MAC-array multiplier: holds W and X,
// streams them in outer-product order, then collects the 9 results.
module mm_operand_sequencer #(
    parameter int DW = 4,
    parameter int RW = 10,
    parameter int N  = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic          wr_sel,
    input  logic [3:0]    wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] mm_w1,
    output logic [DW-1:0] mm_w2,
    output logic [DW-1:0] mm_w3,
    output logic [DW-1:0] mm_x1,
    output logic [DW-1:0] mm_x2,
    output logic [DW-1:0] mm_x3,
    output logic          mm_load,
    output logic          mm_clear,
    output logic          mm_unload_res,
    input  logic [RW-1:0] mm_data_out,
    input  logic [3:0]    rd_addr,
    output logic [RW-1:0] rd_data
);

    localparam int NE = N * N;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_LOAD,
        S_UNLOAD,
        S_DONE
    } state_t;

    state_t        state;
    logic [1:0]    k;
    logic [3:0]    idx;
    logic [DW-1:0] w_mem   [NE];
    logic [DW-1:0] x_mem   [NE];
    logic [RW-1:0] res_buf [NE];

    logic [1:0] k_nxt;
    logic [3:0] kw;
    logic [3:0] kx;

    // Index of the W column / X row to present on the next LOAD cycle
    always_comb begin
        k_nxt = 2'd0;
        if (state == S_LOAD) k_nxt = k + 2'd1;
        kw = {2'b00, k_nxt};
        kx = kw * 4'd3;
    end

    // Host writes into the operand buffers, only while idle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NE; i++) begin
                w_mem[i] <= '0;
                x_mem[i] <= '0;
            end
        end else if (wr_en && state == S_IDLE && wr_addr < 4'(NE)) begin
            if (wr_sel) x_mem[wr_addr] <= wr_data;
            else        w_mem[wr_addr] <= wr_data;
        end
    end

    // Sequencing FSM with registered multiplier controls and result capture
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= S_IDLE;
            k             <= '0;
            idx           <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            mm_load       <= 1'b0;
            mm_clear      <= 1'b0;
            mm_unload_res <= 1'b0;
            mm_w1         <= '0;
            mm_w2         <= '0;
            mm_w3         <= '0;
            mm_x1         <= '0;
            mm_x2         <= '0;
            mm_x3         <= '0;
            for (int i = 0; i < NE; i++) res_buf[i] <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        state    <= S_CLEAR;
                        busy     <= 1'b1;
                        mm_clear <= 1'b1;
                    end
                end
                S_CLEAR, S_LOAD: begin
                    mm_clear <= 1'b0;
                    if (state == S_LOAD && k == 2'd2) begin
                        state         <= S_UNLOAD;
                        idx           <= '0;
                        mm_load       <= 1'b0;
                        mm_unload_res <= 1'b1;
                        mm_w1         <= '0;
                        mm_w2         <= '0;
                        mm_w3         <= '0;
                        mm_x1         <= '0;
                        mm_x2         <= '0;
                        mm_x3         <= '0;
                    end else begin
                        state   <= S_LOAD;
                        k       <= k_nxt;
                        mm_load <= 1'b1;
                        mm_w1   <= w_mem[kw];
                        mm_w2   <= w_mem[kw + 4'd3];
                        mm_w3   <= w_mem[kw + 4'd6];
                        mm_x1   <= x_mem[kx];
                        mm_x2   <= x_mem[kx + 4'd1];
                        mm_x3   <= x_mem[kx + 4'd2];
                    end
                end
                S_UNLOAD: begin
                    res_buf[idx] <= mm_data_out;
                    if (idx == 4'(NE - 1)) begin
                        state         <= S_DONE;
                        mm_unload_res <= 1'b0;
                        done          <= 1'b1;
                    end else begin
                        idx <= idx + 4'd1;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Result read port; out-of-range addresses read as zero
    always_comb begin
        rd_data = '0;
        if (rd_addr < 4'(NE)) rd_data = res_buf[rd_addr];
    end

endmodule

// File: tb/tb_mm_operand_sequencer.sv
// Bench for mm_operand_sequencer: MAC-array stand-in, directed
// matrices with hand-computed products, protocol and reset checks.
module tb_mm_operand_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr_en = 1'b0;
    logic       wr_sel = 1'b0;
    logic [3:0] wr_addr = '0;
    logic [3:0] wr_data = '0;
    logic       start = 1'b0;
    logic       busy, done;
    logic [3:0] mm_w1, mm_w2, mm_w3, mm_x1, mm_x2, mm_x3;
    logic       mm_load, mm_clear, mm_unload_res;
    logic [9:0] mm_data_out;
    logic [3:0] rd_addr = '0;
    logic [9:0] rd_data;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mm_operand_sequencer dut (
        .clk           (clk),
        .rst           (rst),
        .wr_en         (wr_en),
        .wr_sel        (wr_sel),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data),
        .start         (start),
        .busy          (busy),
        .done          (done),
        .mm_w1         (mm_w1),
        .mm_w2         (mm_w2),
        .mm_w3         (mm_w3),
        .mm_x1         (mm_x1),
        .mm_x2         (mm_x2),
        .mm_x3         (mm_x3),
        .mm_load       (mm_load),
        .mm_clear      (mm_clear),
        .mm_unload_res (mm_unload_res),
        .mm_data_out   (mm_data_out),
        .rd_addr       (rd_addr),
        .rd_data       (rd_data)
    );

    // Stand-in for the MAC array: outer-product accumulate, serial unload
    logic [9:0] acc [9];
    logic [3:0] m_idx;
    logic [3:0] wv [3];
    logic [3:0] xv [3];
    assign wv[0] = mm_w1;
    assign wv[1] = mm_w2;
    assign wv[2] = mm_w3;
    assign xv[0] = mm_x1;
    assign xv[1] = mm_x2;
    assign xv[2] = mm_x3;
    assign mm_data_out = acc[m_idx];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 9; i++) acc[i] <= '0;
            m_idx <= '0;
        end else begin
            if (mm_clear) begin
                for (int i = 0; i < 9; i++) acc[i] <= '0;
                m_idx <= '0;
            end else if (mm_load) begin
                for (int r = 0; r < 3; r++)
                    for (int c = 0; c < 3; c++)
                        acc[r*3+c] <= acc[r*3+c] + 10'(wv[r]) * 10'(xv[c]);
            end
            if (mm_unload_res) m_idx <= (m_idx == 4'd8) ? 4'd0 : m_idx + 4'd1;
        end
    end

    // Pulse counters, one sample per cycle
    int n_clr = 0, n_ld = 0, n_unl = 0, n_done = 0;
    always @(negedge clk) begin
        if (mm_clear)      n_clr++;
        if (mm_load)       n_ld++;
        if (mm_unload_res) n_unl++;
        if (done)          n_done++;
    end

    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic wr(input logic sel, input logic [3:0] a, input logic [3:0] d);
        @(negedge clk);
        wr_en = 1'b1; wr_sel = sel; wr_addr = a; wr_data = d;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic ld(input logic sel, input int v[9]);
        for (int i = 0; i < 9; i++) wr(sel, 4'(i), 4'(v[i]));
    endtask

    task automatic chk_buf(input string tag, input int e[9]);
        for (int i = 0; i < 9; i++) begin
            rd_addr = 4'(i);
            #1;
            check($sformatf("%s[%0d]", tag, i), int'(rd_data), e[i]);
        end
    endtask

    task automatic chk_zero(input string tag);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_done"}, int'(done), 0);
        check({tag, "_ctl"}, int'({mm_load, mm_clear, mm_unload_res}), 0);
        check({tag, "_ops"}, int'({mm_w1, mm_w2, mm_w3, mm_x1, mm_x2, mm_x3}), 0);
    endtask

    // Operands seen on the second LOAD cycle
    logic [23:0] k1_ops;

    // One run; optional write with start, optional write+start poke while busy.
    // Returns the falling-edge count from the start edge to done.
    task automatic run_mm(input bit ws, input logic [3:0] a, input logic [3:0] d,
                          input bit poke, output int lat);
        int n;
        @(negedge clk);
        start = 1'b1;
        if (ws) begin
            wr_en = 1'b1; wr_sel = 1'b0; wr_addr = a; wr_data = d;
        end
        @(negedge clk);
        start = 1'b0; wr_en = 1'b0;
        n = 1;
        while (!done && n < 40) begin
            if (n == 3) k1_ops = {mm_w1, mm_w2, mm_w3, mm_x1, mm_x2, mm_x3};
            if (poke && n == 5) begin
                wr_en = 1'b1; wr_sel = 1'b0; wr_addr = 4'd0; wr_data = 4'd7;
                start = 1'b1;
            end else begin
                wr_en = 1'b0; start = 1'b0;
            end
            @(negedge clk);
            n++;
        end
        wr_en = 1'b0; start = 1'b0;
        if (!done) check("done_timeout", 0, 1);
        lat = n;
    endtask

    int e_zero [9] = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
    int m_id   [9] = '{1, 0, 0, 0, 1, 0, 0, 0, 1};
    int m_19   [9] = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
    int m_91   [9] = '{9, 8, 7, 6, 5, 4, 3, 2, 1};
    int m_15   [9] = '{15, 15, 15, 15, 15, 15, 15, 15, 15};
    int e_max  [9] = '{675, 675, 675, 675, 675, 675, 675, 675, 675};
    int e_ord  [9] = '{30, 24, 18, 84, 69, 54, 138, 114, 90};
    int e_ws   [9] = '{84, 72, 60, 84, 69, 54, 138, 114, 90};

    initial begin
        int lat;
        int c0, l0, u0, d0;

        // Reset state
        #12;
        chk_zero("rst0");
        chk_buf("rst0_rd", e_zero);
        @(negedge clk);
        rst = 1'b0;

        // Identity
        ld(1'b0, m_id);
        ld(1'b1, m_19);
        run_mm(1'b0, 4'd0, 4'd0, 1'b0, lat);
        check("id_lat", lat, 14);
        chk_buf("id", m_19);

        // Reset mid-LOAD clears everything at once
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("pre_rst_clear", int'(mm_clear), 1);
        @(negedge clk);
        check("pre_rst_load", int'(mm_load), 1);
        rst = 1'b1;
        #1;
        chk_zero("rst1");
        chk_buf("rst1_rd", e_zero);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("rst1_idle", int'(busy), 0);

        // Max values
        ld(1'b0, m_15);
        ld(1'b1, m_15);
        run_mm(1'b0, 4'd0, 4'd0, 1'b0, lat);
        chk_buf("max", e_max);

        // Operand order
        ld(1'b0, m_19);
        ld(1'b1, m_91);
        run_mm(1'b0, 4'd0, 4'd0, 1'b0, lat);
        check("ord_k1_ops", int'(k1_ops), int'({4'd2, 4'd5, 4'd8, 4'd6, 4'd5, 4'd4}));
        chk_buf("ord", e_ord);

        // Protocol: write and start while busy are dropped
        c0 = n_clr; l0 = n_ld; u0 = n_unl; d0 = n_done;
        run_mm(1'b0, 4'd0, 4'd0, 1'b1, lat);
        check("poke_lat", lat, 14);
        repeat (20) @(negedge clk);
        check("cnt_clear", n_clr - c0, 1);
        check("cnt_load", n_ld - l0, 3);
        check("cnt_unload", n_unl - u0, 9);
        check("cnt_done", n_done - d0, 1);
        check("poke_idle", int'(busy), 0);

        // Address bounds
        wr(1'b0, 4'd12, 4'd15);
        rd_addr = 4'd9;
        #1;
        check("rd9", int'(rd_data), 0);
        run_mm(1'b0, 4'd0, 4'd0, 1'b0, lat);
        chk_buf("bound", e_ord);

        // Write on the start edge is used by that run
        run_mm(1'b1, 4'd0, 4'd7, 1'b0, lat);
        chk_buf("wstart", e_ws);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
